// File: rtl/present80_round_ctrl.sv
// Iterative PRESENT-80 encryption controller: one round per clock over a 64-bit
// state and an 80-bit key register, with valid/ready handshakes on both sides.
module present80_round_ctrl #(
  parameter int unsigned ROUNDS = 31
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] din_i,
  input  logic [79:0] key_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] dout_o,
  output logic        busy_o
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  rnd_q, rnd_d;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Round datapath: add round key, substitute, permute.
  logic [63:0] rk_xor;
  logic [63:0] sb_out;
  logic [63:0] p_out;

  assign rk_xor = state_q ^ key_q[79:16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign sb_out[4*gi +: 4] = sbox4(rk_xor[4*gi +: 4]);
  end

  for (genvar gi = 0; gi < 63; gi++) begin : g_perm
    localparam int DST = (16 * gi) % 63;
    assign p_out[DST] = sb_out[gi];
  end
  assign p_out[63] = sb_out[63];

  // Key schedule: rotate left by 61, s-box the top nibble, fold in the round counter.
  logic [79:0] key_rot;
  logic [79:0] key_ks;

  assign key_rot = {key_q[18:0], key_q[79:19]};
  assign key_ks  = {sbox4(key_rot[79:76]),
                    key_rot[75:20],
                    key_rot[19:15] ^ rnd_q,
                    key_rot[14:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          state_d = din_i;
          key_d   = key_i;
          rnd_d   = 5'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = p_out;
        key_d   = key_ks;
        if (rnd_q == LAST_RND) begin
          fsm_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state; dout carries the final key whitening.
  assign in_ready_o  = (fsm_q == ST_IDLE);
  assign out_valid_o = (fsm_q == ST_DONE);
  assign busy_o      = (fsm_q == ST_RUN);
  assign dout_o      = rk_xor;

endmodule

// File: tb/tb_present80_round_ctrl.sv
// Directed bench for present80_round_ctrl: known-answer vectors, handshake
// stalls, back-to-back throughput, mid-run reset and a one-round instance.
module tb_present80_round_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [63:0] din1;
  logic [79:0] key1;
  logic        out_valid1;
  logic        out_ready1;
  logic [63:0] dout1;
  logic        busy1;

  int checks;
  int errors;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] P1 = {64{1'b1}};

  present80_round_ctrl #(.ROUNDS(31)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .din_i       (din),
    .key_i       (key),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .dout_o      (dout),
    .busy_o      (busy)
  );

  present80_round_ctrl #(.ROUNDS(1)) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid1),
    .in_ready_o  (in_ready1),
    .din_i       (din1),
    .key_i       (key1),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready1),
    .dout_o      (dout1),
    .busy_o      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block through the 31-round instance; optional output stall with in_valid held high.
  task automatic run_vec(input logic [63:0] d, input logic [79:0] k, input logic [63:0] exp,
                         input string tag, input int hold_cycles);
    int cycles;
    int busy_cnt;
    chk({tag, "_in_ready"}, 80'(in_ready), 80'd1);
    din = d;
    key = k;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    $display("vector %s: latency=%0d busy_cycles=%0d dout=%h", tag, cycles, busy_cnt, dout);
    chk({tag, "_latency"}, 80'(cycles), 80'd31);
    chk({tag, "_busy_cycles"}, 80'(busy_cnt), 80'd31);
    chk({tag, "_out_valid"}, 80'(out_valid), 80'd1);
    chk({tag, "_dout"}, 80'(dout), 80'(exp));
    if (hold_cycles > 0) begin
      in_valid = 1'b1;
      din = ~d;
      key = ~k;
      for (int i = 0; i < hold_cycles; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_valid"}, 80'(out_valid), 80'd1);
        chk({tag, "_hold_dout"}, 80'(dout), 80'(exp));
        chk({tag, "_hold_in_ready"}, 80'(in_ready), 80'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 80'(out_valid), 80'd0);
    chk({tag, "_post_in_ready"}, 80'(in_ready), 80'd1);
  endtask

  int          acc_cyc [2];
  logic [63:0] out_val [2];
  int          n_acc;
  int          n_out;
  int          cyc;
  int          spurious;
  bit          switch_pending;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    din = '0;
    key = '0;
    out_ready = 1'b0;
    in_valid1 = 1'b0;
    din1 = '0;
    key1 = '0;
    out_ready1 = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_dout", 80'(dout), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // out_ready while idle must not disturb anything.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_ready_ignored", 80'(out_valid), 80'd0);

    run_vec(P0, K0, 64'h5579C1387B228445, "v1", 0);
    run_vec(P0, K1, 64'hE72C46C0F5945049, "v2", 0);
    run_vec(P1, K0, 64'hA112FFC72F68417B, "v3", 10);
    run_vec(P1, K1, 64'h3333DCD3213210D2, "v4", 0);

    // Back-to-back: v1 then v4 under continuous in_valid/out_ready.
    n_acc = 0;
    n_out = 0;
    cyc = 0;
    switch_pending = 1'b0;
    din = P0;
    key = K0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (n_out < 2 && cyc < 200) begin
      if (switch_pending) begin
        din = P1;
        key = K1;
        switch_pending = 1'b0;
        if (n_acc == 2) in_valid = 1'b0;
      end
      if (out_valid) begin
        out_val[n_out] = dout;
        n_out++;
      end
      if (in_valid && in_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        switch_pending = 1'b1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("back-to-back: accepts=%0d outputs=%0d spacing=%0d", n_acc, n_out, acc_cyc[1] - acc_cyc[0]);
    chk("b2b_accepts", 80'(n_acc), 80'd2);
    chk("b2b_outputs", 80'(n_out), 80'd2);
    chk("b2b_spacing", 80'(acc_cyc[1] - acc_cyc[0]), 80'd33);
    chk("b2b_dout0", 80'(out_val[0]), 80'h5579C1387B228445);
    chk("b2b_dout1", 80'(out_val[1]), 80'h3333DCD3213210D2);
    @(negedge clk);

    // Reset during round 15 abandons the block.
    din = P0;
    key = K0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_busy", 80'(busy), 80'd1);
    rst_n = 1'b0;
    #1;
    $display("mid-run reset: in_ready=%0b out_valid=%0b busy=%0b dout=%h", in_ready, out_valid, busy, dout);
    chk("midrst_in_ready", 80'(in_ready), 80'd1);
    chk("midrst_out_valid", 80'(out_valid), 80'd0);
    chk("midrst_busy", 80'(busy), 80'd0);
    chk("midrst_dout", 80'(dout), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid || busy) spurious++;
    end
    chk("midrst_no_spurious", 80'(spurious), 80'd0);
    run_vec(P0, K0, 64'h5579C1387B228445, "v1_after_rst", 0);

    // One-round instance: accept, single round, then DONE.
    din1 = P0;
    key1 = K0;
    in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("r1_busy", 80'(busy1), 80'd1);
    chk("r1_valid_early", 80'(out_valid1), 80'd0);
    @(posedge clk);
    @(negedge clk);
    $display("rounds=1: out_valid=%0b dout=%h", out_valid1, dout1);
    chk("r1_valid", 80'(out_valid1), 80'd1);
    chk("r1_dout", 80'(dout1), 80'h3FFFFFFF00000000);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("r1_post_valid", 80'(out_valid1), 80'd0);
    chk("r1_post_in_ready", 80'(in_ready1), 80'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
